rr_arb_mux_4_1: RTL and testbench

// Upstream stage for the 4:1 case-mux: four requesters with valid/ready each offer a

---
 rtl/rr_arb_mux_4_1.sv | 93 +++++++++
 tb/tb_rr_arb_mux_4_1.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter for four valid/ready requesters feeding a single-entry output buffer.
// The buffer registers the granted word and its 2-bit select code for the downstream 4:1 mux.
module rr_arb_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  logic [1:0]       r_prio;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;

  logic [1:0]       w_gnt;
  logic [1:0]       w_idx;
  logic             w_found;
  logic             w_load;
  logic [WIDTH-1:0] w_gnt_data;

  // Scan from the priority pointer upward (mod 4); first valid requester wins.
  always_comb begin
    w_gnt   = r_prio;
    w_idx   = r_prio;
    w_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_prio + 2'(k);
      if (!w_found && in_valid[w_idx]) begin
        w_gnt   = w_idx;
        w_found = 1'b1;
      end else begin
        w_gnt   = w_gnt;
      end
    end
  end

  // Select the granted requester's word.
  always_comb begin
    case (w_gnt)
      2'd0:    w_gnt_data = d0;
      2'd1:    w_gnt_data = d1;
      2'd2:    w_gnt_data = d2;
      2'd3:    w_gnt_data = d3;
      default: w_gnt_data = d0;
    endcase
  end

  // A word is taken when someone is offering and the buffer is empty or draining.
  assign w_load = (|in_valid) & (~r_valid | out_ready) & ~rst;

  // One-hot acknowledge to the granted requester only on a load cycle.
  always_comb begin
    if (w_load) begin
      in_ready = 4'b0001 << w_gnt;
    end else begin
      in_ready = 4'b0000;
    end
  end

  // Output buffer and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_prio  <= 2'd0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_sel   <= w_gnt;
      r_prio  <= w_gnt + 2'd1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed checks of rr_arb_mux_4_1 followed by a random valid/ready run against a reference model.
module tb_rr_arb_mux_4_1;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_sel;

  int n_pass;
  int n_total;

  rr_arb_mux_4_1 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_sel"},   {30'd0, out_sel},   {30'd0, s});
    chk({tag, "_data"},  {28'd0, out_data},  {28'd0, d});
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] v);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (v[idx]) rr_pick = idx;
    end
  endfunction

  logic [3:0] pend_v;
  logic [3:0] pend_d [4];
  logic       m_full;
  logic [1:0] m_prio;
  logic [1:0] m_sel;
  logic [3:0] m_data;
  logic       m_load;
  logic [1:0] m_g;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;

    // Reset state and no grant while in reset
    tick();
    tick();
    chk_out("rst", 1'b0, 2'd0, 4'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("first_grant", {28'd0, in_ready}, 32'h1);

    // All valid round-robin sequence
    tick(); chk_out("rr0", 1'b1, 2'd0, 4'd1);
    tick(); chk_out("rr1", 1'b1, 2'd1, 4'd2);
    tick(); chk_out("rr2", 1'b1, 2'd2, 4'd3);
    tick(); chk_out("rr3", 1'b1, 2'd3, 4'd4);
    tick(); chk_out("rr4", 1'b1, 2'd0, 4'd1);
    tick(); chk_out("rr5", 1'b1, 2'd1, 4'd2);

    // Asynchronous reset while full
    rst = 1'b1;
    #1;
    chk_out("midrst", 1'b0, 2'd0, 4'd0);
    chk("midrst_in_ready", {28'd0, in_ready}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_grant", {28'd0, in_ready}, 32'h1);
    tick(); chk_out("rst2_out", 1'b1, 2'd0, 4'd1);

    // Single requester
    in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("solo_in_ready", {28'd0, in_ready}, 32'h4);
      tick();
      chk_out("solo", 1'b1, 2'd2, 4'd3);
    end

    // Backpressure: hold sel=1 data=5
    d1 = 4'd5;
    in_valid = 4'b0010;
    tick();
    chk_out("bp_load", 1'b1, 2'd1, 4'd5);
    in_valid = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {28'd0, in_ready}, 32'h0);
      tick();
      chk_out("bp_hold", 1'b1, 2'd1, 4'd5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_in_ready", {28'd0, in_ready}, 32'h4);
    tick(); chk_out("bp_rel", 1'b1, 2'd2, 4'd3);

    // Pointer wrap
    tick(); chk_out("wrap3", 1'b1, 2'd3, 4'd4);
    in_valid = 4'b0101;
    tick(); chk_out("wrap0", 1'b1, 2'd0, 4'd1);
    tick(); chk_out("wrap2", 1'b1, 2'd2, 4'd3);
    in_valid = 4'b0010;
    #1;
    chk("wrap1_in_ready", {28'd0, in_ready}, 32'h2);
    tick(); chk_out("wrap1", 1'b1, 2'd1, 4'd5);

    // Drain with no requesters
    in_valid = 4'b0000;
    #1;
    chk("drain_in_ready", {28'd0, in_ready}, 32'h0);
    tick(); chk_out("drain", 1'b0, 2'd1, 4'd5);
    tick(); chk_out("drain2", 1'b0, 2'd1, 4'd5);

    // Random run against a reference model of buffer and pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pend_v = 4'b0000;
    for (int i = 0; i < 4; i++) pend_d[i] = 4'd0;
    m_full = 1'b0; m_prio = 2'd0; m_sel = 2'd0; m_data = 4'd0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
          pend_v[i] = 1'b1;
          pend_d[i] = 4'($urandom_range(0, 15));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = pend_v;
      d0 = pend_d[0]; d1 = pend_d[1]; d2 = pend_d[2]; d3 = pend_d[3];
      #1;
      m_load = (|pend_v) && (!m_full || out_ready);
      m_g = rr_pick(m_prio, pend_v);
      chk("rnd_in_ready", {28'd0, in_ready}, m_load ? (32'h1 << m_g) : 32'h0);
      chk("rnd_valid", {31'd0, out_valid}, {31'd0, m_full});
      if (m_full) begin
        chk("rnd_sel",  {30'd0, out_sel},  {30'd0, m_sel});
        chk("rnd_data", {28'd0, out_data}, {28'd0, m_data});
      end
      tick();
      if (m_load) begin
        m_full = 1'b1;
        m_sel = m_g;
        m_data = pend_d[m_g];
        m_prio = m_g + 2'd1;
        pend_v[m_g] = 1'b0;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
